// File: rtl/udp_rx_strip8.sv
// UDP receive stripper: captures the 8-byte UDP header from an sop/eop byte
// stream, optionally filters on destination port and forwards the payload.
module udp_rx_strip8 #(
  parameter int AVL_SIZE       = 8,
  parameter int HDR_LEN        = 8,
  parameter int PORT_FILTER_EN = 1
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic [15:0]         local_port,
  input  logic                in_valid,
  input  logic [AVL_SIZE-1:0] in_data,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic                out_valid,
  output logic [AVL_SIZE-1:0] out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic                out_err,
  output logic                hdr_valid,
  output logic [15:0]         src_port,
  output logic [15:0]         dst_port,
  output logic [15:0]         payload_len,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DISCARD} state_t;

  localparam int HW = 6 * AVL_SIZE;

  state_t        r_state;
  logic [HW-1:0] r_hdr;
  logic [2:0]    r_cnt;
  logic [15:0]   r_rem;
  logic          r_first;

  // Checksum bytes (6,7) are never stored; only ports and length matter here.
  logic [15:0] w_src, w_dst, w_len;
  logic        w_hdr_last, w_port_bad, w_len_bad, w_drop;

  assign w_src      = r_hdr[47:32];
  assign w_dst      = r_hdr[31:16];
  assign w_len      = r_hdr[15:0];
  assign w_hdr_last = (r_state == S_HDR) && in_valid && (r_cnt == 3'(HDR_LEN - 1));
  assign w_port_bad = (PORT_FILTER_EN != 0) && (w_dst != local_port);
  assign w_len_bad  = w_len < 16'(HDR_LEN);
  assign w_drop     = ((r_state == S_IDLE) && in_valid && in_sop && in_eop)
                   || ((r_state == S_HDR) && in_valid && !w_hdr_last && in_eop)
                   || (w_hdr_last && (w_len_bad || w_port_bad));

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state     <= S_IDLE;
      r_hdr       <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_first     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_err     <= 1'b0;
      hdr_valid   <= 1'b0;
      src_port    <= '0;
      dst_port    <= '0;
      payload_len <= '0;
      drop_cnt    <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      hdr_valid <= 1'b0;
      if (w_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (in_valid && in_sop) begin
            r_hdr <= {r_hdr[HW-AVL_SIZE-1:0], in_data};
            r_cnt <= 3'd1;
            if (!in_eop) r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (in_valid) begin
            if (r_cnt < 3'd6) r_hdr <= {r_hdr[HW-AVL_SIZE-1:0], in_data};
            if (w_hdr_last) begin
              if (w_len_bad || w_port_bad) begin
                r_state <= in_eop ? S_IDLE : S_DISCARD;
              end else begin
                hdr_valid   <= 1'b1;
                src_port    <= w_src;
                dst_port    <= w_dst;
                payload_len <= w_len - 16'(HDR_LEN);
                r_rem       <= w_len - 16'(HDR_LEN);
                r_first     <= 1'b1;
                if (in_eop)                        r_state <= S_IDLE;
                else if (w_len == 16'(HDR_LEN))    r_state <= S_DISCARD;
                else                               r_state <= S_PAYLOAD;
              end
            end else if (in_eop) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_sop   <= r_first;
            r_first   <= 1'b0;
            r_rem     <= r_rem - 16'd1;
            if (r_rem == 16'd1) begin
              out_eop <= 1'b1;
              r_state <= in_eop ? S_IDLE : S_DISCARD;
            end else if (in_eop) begin
              out_eop <= 1'b1;
              out_err <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (in_valid && in_eop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_strip8.sv
// Bench for udp_rx_strip8: directed vector table plus random frames checked
// against a frame-level reference model, on filtering and non-filtering DUTs.
module tb_udp_rx_strip8;
  localparam logic [15:0] LP = 16'h0FA0;

  logic        clk = 1'b0;
  logic        sync_reset, in_valid, in_sop, in_eop;
  logic [7:0]  in_data;
  logic [15:0] local_port;

  logic        f_valid, f_sop, f_eop, f_err, f_hdr;
  logic [7:0]  f_data;
  logic [15:0] f_src, f_dst, f_plen, f_drop;
  logic        n_valid, n_sop, n_eop, n_err, n_hdr;
  logic [7:0]  n_data;
  logic [15:0] n_src, n_dst, n_plen, n_drop;

  udp_rx_strip8 #(.AVL_SIZE(8), .HDR_LEN(8), .PORT_FILTER_EN(1)) u_dut (
    .clk(clk), .sync_reset(sync_reset), .local_port(local_port),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(f_valid), .out_data(f_data), .out_sop(f_sop), .out_eop(f_eop),
    .out_err(f_err), .hdr_valid(f_hdr), .src_port(f_src), .dst_port(f_dst),
    .payload_len(f_plen), .drop_cnt(f_drop));

  udp_rx_strip8 #(.AVL_SIZE(8), .HDR_LEN(8), .PORT_FILTER_EN(0)) u_dut_nf (
    .clk(clk), .sync_reset(sync_reset), .local_port(local_port),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(n_valid), .out_data(n_data), .out_sop(n_sop), .out_eop(n_eop),
    .out_err(n_err), .hdr_valid(n_hdr), .src_port(n_src), .dst_port(n_dst),
    .payload_len(n_plen), .drop_cnt(n_drop));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         sop, eop, err;
    int         cyc;
  } beat_t;

  beat_t act_f[$], act_n[$], exp_q[$];
  int    hdr_f = 0, hdr_n = 0;

  always @(negedge clk) begin
    if (f_valid) act_f.push_back('{f_data, f_sop, f_eop, f_err, cyc});
    if (n_valid) act_n.push_back('{n_data, n_sop, n_eop, n_err, cyc});
    if (f_hdr) hdr_f++;
    if (n_hdr) hdr_n++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input int a, input int e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  logic [7:0] fr[$];
  int         fr_cyc[$];
  bit         fr_gap;
  logic [7:0] pat[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic build_frame(input logic [15:0] dst, input logic [15:0] len,
                             input int npost, input int trunc);
    fr.delete();
    fr.push_back(8'h12); fr.push_back(8'h34);
    fr.push_back(dst[15:8]); fr.push_back(dst[7:0]);
    fr.push_back(len[15:8]); fr.push_back(len[7:0]);
    fr.push_back(8'h00); fr.push_back(8'h00);
    for (int k = 0; k < npost; k++) fr.push_back(k < 4 ? pat[k] : 8'($urandom));
    if (trunc > 0) while (fr.size() > trunc + 1) void'(fr.pop_back());
  endtask

  // Drives bytes [from, to) of the current frame; sop/eop mark its real ends.
  task automatic send_bytes(input int from, input int to);
    for (int i = from; i < to; i++) begin
      if (fr_gap) repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fr[i];
      in_sop   = (i == 0);
      in_eop   = (i == fr.size() - 1);
      fr_cyc.push_back(cyc);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_frame();
    act_f.delete(); act_n.delete(); fr_cyc.delete();
    hdr_f = 0; hdr_n = 0;
    send_bytes(0, fr.size());
    repeat (3) @(negedge clk);
  endtask

  // Reference model: whole-frame view derived from the UDP framing rules.
  bit          exp_hdr, exp_drop;
  logic [15:0] exp_plen;
  int          drop_m_f = 0, drop_m_n = 0;

  task automatic run_model(input bit filt);
    int n, avail, nb;
    logic [15:0] len, dst;
    n = fr.size();
    exp_q.delete(); exp_hdr = 0; exp_drop = 0; exp_plen = 0;
    if (n < 8) begin
      exp_drop = 1;
    end else begin
      len = {fr[4], fr[5]};
      dst = {fr[2], fr[3]};
      if (len < 16'd8 || (filt && dst != local_port)) begin
        exp_drop = 1;
      end else begin
        exp_hdr  = 1;
        exp_plen = len - 16'd8;
        avail    = n - 8;
        nb       = (avail < int'(exp_plen)) ? avail : int'(exp_plen);
        for (int k = 0; k < nb; k++)
          exp_q.push_back('{fr[8+k], k == 0, k == nb - 1,
                            (k == nb - 1) && (avail < int'(exp_plen)), fr_cyc[8+k] + 1});
      end
    end
  endtask

  task automatic compare(input bit filt);
    beat_t aq[$];
    int    hc, m;
    logic [15:0] src, dst, plen, drop;
    run_model(filt);
    if (filt) begin
      aq = act_f; hc = hdr_f; src = f_src; dst = f_dst; plen = f_plen; drop = f_drop;
      drop_m_f += int'(exp_drop);
    end else begin
      aq = act_n; hc = hdr_n; src = n_src; dst = n_dst; plen = n_plen; drop = n_drop;
      drop_m_n += int'(exp_drop);
    end
    check(filt ? "f_beat_count" : "n_beat_count", aq.size(), exp_q.size());
    m = (aq.size() < exp_q.size()) ? aq.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      check(filt ? "f_beat" : "n_beat", int'({aq[k].d, aq[k].sop, aq[k].eop, aq[k].err}),
            int'({exp_q[k].d, exp_q[k].sop, exp_q[k].eop, exp_q[k].err}));
      check(filt ? "f_beat_cycle" : "n_beat_cycle", aq[k].cyc, exp_q[k].cyc);
    end
    check(filt ? "f_hdr_pulses" : "n_hdr_pulses", hc, int'(exp_hdr));
    if (exp_hdr) begin
      check("src_port", int'(src), int'({fr[0], fr[1]}));
      check("dst_port", int'(dst), int'({fr[2], fr[3]}));
      check("payload_len", int'(plen), int'(exp_plen));
    end
    check(filt ? "f_drop_cnt" : "n_drop_cnt", int'(drop), filt ? drop_m_f : drop_m_n);
  endtask

  typedef struct {
    logic [15:0] dst, len;
    int          npost, trunc;
    bit          gap;
    int          ebeats;
    bit          eerr;
    int          ehdr, edrop;
  } vec_t;

  vec_t vt[10];

  task automatic check_reset_state();
    check("rst_out", int'({f_valid, f_sop, f_eop, f_err, f_hdr, f_data}), 0);
    check("rst_ports", int'({f_src, f_dst}), 0);
    check("rst_len_drop", int'({f_plen, f_drop}), 0);
    check("rst_nf_out", int'({n_valid, n_hdr, n_drop}), 0);
  endtask

  initial begin
    int d0, len, npost, trunc;
    logic [15:0] dst;
    vt[0] = '{16'h0FA0, 16'h000C,  4, 0, 0, 4, 0, 1, 0};
    vt[1] = '{16'h0FA0, 16'h000A, 10, 0, 0, 2, 0, 1, 0};
    vt[2] = '{16'h0050, 16'h000C,  4, 0, 0, 0, 0, 0, 1};
    vt[3] = '{16'h0FA0, 16'h000C,  4, 5, 0, 0, 0, 0, 1};
    vt[4] = '{16'h0FA0, 16'h0010,  3, 0, 0, 3, 1, 1, 0};
    vt[5] = '{16'h0FA0, 16'h0004,  4, 0, 0, 0, 0, 0, 1};
    vt[6] = '{16'h0FA0, 16'h0008,  0, 0, 0, 0, 0, 1, 0};
    vt[7] = '{16'h0FA0, 16'h0008,  3, 0, 0, 0, 0, 1, 0};
    vt[8] = '{16'h0FA0, 16'h000C,  4, 0, 1, 4, 0, 1, 0};
    vt[9] = '{16'h0FA0, 16'h0009,  1, 0, 1, 1, 0, 1, 0};

    local_port = LP;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
    sync_reset = 1'b1;
    repeat (3) @(negedge clk);
    sync_reset = 1'b0;
    check_reset_state();

    for (int i = 0; i < 10; i++) begin
      build_frame(vt[i].dst, vt[i].len, vt[i].npost, vt[i].trunc);
      fr_gap = vt[i].gap;
      d0 = int'(f_drop);
      send_frame();
      check("vec_beats", act_f.size(), vt[i].ebeats);
      if (vt[i].ebeats > 0) begin
        check("vec_first_sop", int'(act_f[0].sop), 1);
        check("vec_last_eop_err", int'({act_f[act_f.size()-1].eop, act_f[act_f.size()-1].err}),
              int'({1'b1, vt[i].eerr}));
      end
      check("vec_hdr", hdr_f, vt[i].ehdr);
      check("vec_drop_delta", int'(f_drop) - d0, vt[i].edrop);
      if (i == 2) check("nofilter_forward", act_n.size(), 4);
      compare(1'b1);
      compare(1'b0);
    end

    // Reset after the second payload byte, then the tail of that frame arrives.
    build_frame(LP, 16'h000C, 4, 0);
    fr_gap = 1'b0;
    act_f.delete(); act_n.delete(); fr_cyc.delete();
    send_bytes(0, 10);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    check_reset_state();
    drop_m_f = 0; drop_m_n = 0;
    act_f.delete(); act_n.delete(); hdr_f = 0; hdr_n = 0;
    send_bytes(10, fr.size());
    repeat (3) @(negedge clk);
    check("post_reset_tail_beats", act_f.size() + act_n.size(), 0);
    check("post_reset_tail_hdr", hdr_f + hdr_n, 0);
    build_frame(LP, 16'h000C, 4, 0);
    send_frame();
    compare(1'b1);
    compare(1'b0);

    for (int r = 0; r < 40; r++) begin
      len   = $urandom_range(0, 40);
      npost = $urandom_range(0, 30);
      if (len > 8 && npost == 0) npost = 1;
      dst   = ($urandom_range(0, 1) == 1) ? LP : 16'($urandom);
      trunc = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0;
      fr_gap = 1'($urandom_range(0, 1));
      build_frame(dst, 16'(len), npost, trunc);
      send_frame();
      compare(1'b1);
      compare(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
